can_bit_destuffer: RTL

- Receive-path stage between the bit-timing/sampling logic and the CRC calculator.
- Takes one sampled bus bit per bit time and removes CAN stuff bits (the complement bit inserted after STUFF_LEN equal bits).
- Detects stuff errors and forwards destuffed bits with a valid strobe. The frame decoder and the CRC stage consume those bits.
- Tracks the count of destuffed bits in the current stuffed region.

---
 rtl/can_bit_destuffer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/can_bit_destuffer.sv
// CAN receive-path bit destuffer.
// Sits between bit sampling and the CRC/frame decoder. It removes the
// complement bit inserted after STUFF_LEN equal bits, flags stuff errors
// and counts the destuffed bits forwarded in the current stuffed region.
module can_bit_destuffer #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             rx_bit,
  input  logic             destuff_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             stuff_bit,
  output logic             stuff_err,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);

  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_PASS,
    ST_COUNT,
    ST_EXPECT_STUFF,
    ST_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             dout_d, valid_d, stuff_d, err_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [RUN_W-1:0] run_next;

  // Saturating increment of the forwarded-bit counter.
  assign cnt_inc  = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + CNT_W'(1);
  // Run length if the current bit is forwarded while counting.
  assign run_next = (rx_bit == last_q) ? run_q + RUN_ONE : RUN_ONE;

  // Next-state and registered-output computation for one sample.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d = state_q;
    run_d   = run_q;
    last_d  = last_q;
    dout_d  = dout;
    valid_d = 1'b0;
    stuff_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = bit_cnt;

    if (sample_en) begin
      if (!destuff_en) begin
        // Outside the stuffed region (or leaving it): plain pass-through.
        state_d = ST_PASS;
        run_d   = '0;
        cnt_d   = '0;
        dout_d  = rx_bit;
        valid_d = 1'b1;
      end else begin
        unique case (state_q)
          ST_PASS: begin
            // First bit of the stuffed region starts a fresh run.
            run_d   = RUN_ONE;
            last_d  = rx_bit;
            dout_d  = rx_bit;
            valid_d = 1'b1;
            cnt_d   = cnt_inc;
            state_d = (RUN_ONE == RUN_LIMIT) ? ST_EXPECT_STUFF : ST_COUNT;
          end
          ST_COUNT: begin
            run_d   = run_next;
            last_d  = rx_bit;
            dout_d  = rx_bit;
            valid_d = 1'b1;
            cnt_d   = cnt_inc;
            state_d = (run_next == RUN_LIMIT) ? ST_EXPECT_STUFF : ST_COUNT;
          end
          ST_EXPECT_STUFF: begin
            if (rx_bit != last_q) begin
              // Stuff bit is dropped but begins the next run.
              stuff_d = 1'b1;
              run_d   = RUN_ONE;
              last_d  = rx_bit;
              state_d = (RUN_ONE == RUN_LIMIT) ? ST_EXPECT_STUFF : ST_COUNT;
            end else begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end
          end
          ST_ERR: begin
            // Frame is dead; wait silently for destuff_en to drop.
            state_d = ST_ERR;
          end
          default: state_d = ST_PASS;
        endcase
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all registers updating together.
    if (rst) begin
      state_q    <= ST_PASS;
      run_q      <= '0;
      last_q     <= 1'b1;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      stuff_bit  <= 1'b0;
      stuff_err  <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      last_q     <= last_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      stuff_bit  <= stuff_d;
      stuff_err  <= err_d;
      bit_cnt    <= cnt_d;
    end
  end

endmodule
